// File: rtl/control_unit_pkg.sv
// Shared encodings for the basic-computer control unit: opcodes, register-reference
// bit positions, common-bus sources and AC/E operations.
package control_unit_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam logic [3:0] RR_CLA  = 4'd11;
  localparam logic [3:0] RR_CLE  = 4'd10;
  localparam logic [3:0] RR_CMA  = 4'd9;
  localparam logic [3:0] RR_CME  = 4'd8;
  localparam logic [3:0] RR_CIR  = 4'd7;
  localparam logic [3:0] RR_CIL  = 4'd6;
  localparam logic [3:0] RR_INC  = 4'd5;
  localparam logic [3:0] RR_SPA  = 4'd4;
  localparam logic [3:0] RR_SNA  = 4'd3;
  localparam logic [3:0] RR_SZA  = 4'd2;
  localparam logic [3:0] RR_SZE  = 4'd1;
  localparam logic [3:0] RR_HLT  = 4'd0;
  localparam logic [3:0] RR_NONE = 4'd15;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [3:0] SC_LAST = 4'd6;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_AND, ALU_ADD, ALU_LDA, ALU_CLA, ALU_CLE,
    ALU_CMA, ALU_CME, ALU_CIR, ALU_CIL, ALU_INC
  } alu_op_t;

  typedef enum logic {ST_HALT, ST_RUN} run_state_t;

  // Index of the highest set register-reference bit (bit 11 wins), RR_NONE if none.
  function automatic logic [3:0] rr_pick(input logic [11:0] bits);
    rr_pick = RR_NONE;
    for (int i = 0; i < 12; i++) begin
      if (bits[i]) rr_pick = 4'(i);
    end
  endfunction

endpackage

// File: rtl/control_unit_seq_counter.sv
// 4-bit sequence counter: async clear, synchronous clear has priority over increment.
module seq_counter (
  input  logic       clk,
  input  logic       reset_cu,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk or posedge reset_cu) begin
    if (reset_cu)  count <= 4'd0;
    else if (clr)  count <= 4'd0;
    else if (inc)  count <= count + 4'd1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: run/halt FSM plus a T-state decode that produces the
// register strobes, common-bus select and AC/E operation for each step.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_cu,
  input  logic             start,
  input  logic [WIDTH-1:0] op_of_ir,
  input  logic             ac_neg,
  input  logic             ac_zero,
  input  logic             e_zero,
  input  logic             dr_zero,
  output logic [3:0]       sc,
  output logic             running,
  output logic             ld_ar,
  output logic             inc_ar,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             ld_dr,
  output logic             inc_dr,
  output logic             ld_ac,
  output logic             ld_ir,
  output logic             mem_write,
  output logic [2:0]       bus_sel,
  output logic [3:0]       alu_op
);

  run_state_t state;
  alu_op_t    alu_sel;
  logic [2:0] d;
  logic       ind;
  logic       active;
  logic       step_clr;
  logic       halt_req;
  logic       sc_clr;

  assign d       = op_of_ir[14:12];
  assign ind     = op_of_ir[WIDTH-1];
  assign running = (state == ST_RUN);
  // Reset gates the decode directly so no strobe can escape while reset_cu is high.
  assign active  = running && !reset_cu;
  assign alu_op  = alu_sel;

  always_ff @(posedge clk or posedge reset_cu) begin
    if (reset_cu) begin
      state <= ST_HALT;
    end else begin
      case (state)
        ST_HALT: if (start)    state <= ST_RUN;
        ST_RUN:  if (halt_req) state <= ST_HALT;
        default:               state <= ST_HALT;
      endcase
    end
  end

  // T6 is the last step of any instruction, so clearing there also catches stray values.
  assign sc_clr = !running || step_clr || (sc >= SC_LAST);

  seq_counter u_seq_counter (
    .clk      (clk),
    .reset_cu (reset_cu),
    .clr      (sc_clr),
    .inc      (running),
    .count    (sc)
  );

  always_comb begin
    ld_ar     = 1'b0;
    inc_ar    = 1'b0;
    ld_pc     = 1'b0;
    inc_pc    = 1'b0;
    ld_dr     = 1'b0;
    inc_dr    = 1'b0;
    ld_ac     = 1'b0;
    ld_ir     = 1'b0;
    mem_write = 1'b0;
    bus_sel   = BUS_NONE;
    alu_sel   = ALU_NOP;
    step_clr  = 1'b0;
    halt_req  = 1'b0;
    if (active) begin
      case (sc)
        4'd0: begin
          bus_sel = BUS_PC;
          ld_ar   = 1'b1;
        end
        4'd1: begin
          bus_sel = BUS_MEM;
          ld_ir   = 1'b1;
          inc_pc  = 1'b1;
        end
        4'd2: begin
          bus_sel = BUS_IR;
          ld_ar   = 1'b1;
        end
        4'd3: begin
          if (d == OP_REG) begin
            step_clr = 1'b1;
            if (!ind) begin
              case (rr_pick(op_of_ir[11:0]))
                RR_CLA: alu_sel = ALU_CLA;
                RR_CLE: alu_sel = ALU_CLE;
                RR_CMA: alu_sel = ALU_CMA;
                RR_CME: alu_sel = ALU_CME;
                RR_CIR: alu_sel = ALU_CIR;
                RR_CIL: alu_sel = ALU_CIL;
                RR_INC: alu_sel = ALU_INC;
                RR_SPA: inc_pc  = !ac_neg;
                RR_SNA: inc_pc  = ac_neg;
                RR_SZA: inc_pc  = ac_zero;
                RR_SZE: inc_pc  = e_zero;
                RR_HLT: halt_req = 1'b1;
                default: ;
              endcase
            end
          end else if (ind) begin
            bus_sel = BUS_MEM;
            ld_ar   = 1'b1;
          end
        end
        4'd4: begin
          case (d)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = BUS_MEM;
              ld_dr   = 1'b1;
            end
            OP_STA: begin
              bus_sel   = BUS_AC;
              mem_write = 1'b1;
              step_clr  = 1'b1;
            end
            OP_BUN: begin
              bus_sel  = BUS_AR;
              ld_pc    = 1'b1;
              step_clr = 1'b1;
            end
            OP_BSA: begin
              bus_sel   = BUS_PC;
              mem_write = 1'b1;
              inc_ar    = 1'b1;
            end
            default: ;
          endcase
        end
        4'd5: begin
          case (d)
            OP_AND: begin alu_sel = ALU_AND; ld_ac = 1'b1; step_clr = 1'b1; end
            OP_ADD: begin alu_sel = ALU_ADD; ld_ac = 1'b1; step_clr = 1'b1; end
            OP_LDA: begin alu_sel = ALU_LDA; ld_ac = 1'b1; step_clr = 1'b1; end
            OP_BSA: begin
              bus_sel  = BUS_AR;
              ld_pc    = 1'b1;
              step_clr = 1'b1;
            end
            OP_ISZ: inc_dr = 1'b1;
            default: ;
          endcase
        end
        4'd6: begin
          step_clr = 1'b1;
          if (d == OP_ISZ) begin
            bus_sel   = BUS_DR;
            mem_write = 1'b1;
            inc_pc    = dr_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed per-cycle vector table for control_unit, plus hand sequences for
// asynchronous reset aborting an instruction and resuming from halt.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_cu;
  logic        start;
  logic [15:0] op_of_ir;
  logic        ac_neg, ac_zero, e_zero, dr_zero;
  logic [3:0]  sc;
  logic        running;
  logic        ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_write;
  logic [2:0]  bus_sel;
  logic [3:0]  alu_op;

  localparam logic [8:0] S_NONE   = 9'h000;
  localparam logic [8:0] S_LD_AR  = 9'h100;
  localparam logic [8:0] S_INC_AR = 9'h080;
  localparam logic [8:0] S_LD_PC  = 9'h040;
  localparam logic [8:0] S_INC_PC = 9'h020;
  localparam logic [8:0] S_LD_DR  = 9'h010;
  localparam logic [8:0] S_INC_DR = 9'h008;
  localparam logic [8:0] S_LD_AC  = 9'h004;
  localparam logic [8:0] S_LD_IR  = 9'h002;
  localparam logic [8:0] S_MEM_WR = 9'h001;

  typedef struct {
    logic        start;
    logic [15:0] op;
    logic [3:0]  flags;   // {ac_neg, ac_zero, e_zero, dr_zero}
    logic [20:0] exp;     // {sc, running, strobes[8:0], bus_sel, alu_op}
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  control_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_cu  (reset_cu),
    .start     (start),
    .op_of_ir  (op_of_ir),
    .ac_neg    (ac_neg),
    .ac_zero   (ac_zero),
    .e_zero    (e_zero),
    .dr_zero   (dr_zero),
    .sc        (sc),
    .running   (running),
    .ld_ar     (ld_ar),
    .inc_ar    (inc_ar),
    .ld_pc     (ld_pc),
    .inc_pc    (inc_pc),
    .ld_dr     (ld_dr),
    .inc_dr    (inc_dr),
    .ld_ac     (ld_ac),
    .ld_ir     (ld_ir),
    .mem_write (mem_write),
    .bus_sel   (bus_sel),
    .alu_op    (alu_op)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [20:0] ex(input logic [3:0] sc_e, input logic run_e,
                                     input logic [8:0] strb_e, input logic [2:0] bus_e,
                                     input logic [3:0] alu_e);
    return {sc_e, run_e, strb_e, bus_e, alu_e};
  endfunction

  task automatic add(input logic st, input logic [15:0] op, input logic [3:0] fl,
                     input logic [20:0] e);
    vec_t v;
    v.start = st;
    v.op    = op;
    v.flags = fl;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [15:0] op, input logic [3:0] fl);
    add(1'b0, op, fl, ex(4'd0, 1'b1, S_LD_AR, 3'd2, ALU_NOP));
    add(1'b0, op, fl, ex(4'd1, 1'b1, S_LD_IR | S_INC_PC, 3'd7, ALU_NOP));
    add(1'b0, op, fl, ex(4'd2, 1'b1, S_LD_AR, 3'd5, ALU_NOP));
  endtask

  task automatic add_rr(input logic [15:0] op, input logic [3:0] fl,
                        input logic [8:0] strb, input logic [3:0] alu);
    add_fetch(op, fl);
    add(1'b0, op, fl, ex(4'd3, 1'b1, strb, 3'd0, alu));
  endtask

  // driver
  task automatic apply(input vec_t v);
    start    = v.start;
    op_of_ir = v.op;
    {ac_neg, ac_zero, e_zero, dr_zero} = v.flags;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [20:0] exp);
    logic [20:0] got;
    got = {sc, running, ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir,
           mem_write, bus_sel, alu_op};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got sc=%0d run=%b strb=%b bus=%0d alu=%0d exp sc=%0d run=%b strb=%b bus=%0d alu=%0d",
               name, got[20:17], got[16], got[15:7], got[6:4], got[3:0],
               exp[20:17], exp[16], exp[15:7], exp[6:4], exp[3:0]);
    end
  endtask

  initial begin
    reset_cu = 1'b1;
    start    = 1'b0;
    op_of_ir = 16'h0000;
    {ac_neg, ac_zero, e_zero, dr_zero} = 4'b0000;
    #2 check("reset", ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    check("start_in_reset", ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    start    = 1'b0;
    reset_cu = 1'b0;
    @(posedge clk); #1;

    add(1'b1, 16'h0000, 4'b0000, ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    add_rr(16'h7800, 4'b0000, S_NONE, ALU_CLA);
    // ADD, with start pulsed mid-instruction
    add_fetch(16'h1123, 4'b0000);
    add(1'b0, 16'h1123, 4'b0000, ex(4'd3, 1'b1, S_NONE, 3'd0, ALU_NOP));
    add(1'b1, 16'h1123, 4'b0000, ex(4'd4, 1'b1, S_LD_DR, 3'd7, ALU_NOP));
    add(1'b0, 16'h1123, 4'b0000, ex(4'd5, 1'b1, S_LD_AC, 3'd0, ALU_ADD));
    // indirect LDA
    add_fetch(16'hA050, 4'b0000);
    add(1'b0, 16'hA050, 4'b0000, ex(4'd3, 1'b1, S_LD_AR, 3'd7, ALU_NOP));
    add(1'b0, 16'hA050, 4'b0000, ex(4'd4, 1'b1, S_LD_DR, 3'd7, ALU_NOP));
    add(1'b0, 16'hA050, 4'b0000, ex(4'd5, 1'b1, S_LD_AC, 3'd0, ALU_LDA));
    // ISZ with dr_zero=1 then dr_zero=0
    for (int k = 0; k < 2; k++) begin
      logic [3:0] fl;
      fl = (k == 0) ? 4'b0001 : 4'b0000;
      add_fetch(16'h6010, fl);
      add(1'b0, 16'h6010, fl, ex(4'd3, 1'b1, S_NONE, 3'd0, ALU_NOP));
      add(1'b0, 16'h6010, fl, ex(4'd4, 1'b1, S_LD_DR, 3'd7, ALU_NOP));
      add(1'b0, 16'h6010, fl, ex(4'd5, 1'b1, S_INC_DR, 3'd0, ALU_NOP));
      add(1'b0, 16'h6010, fl, ex(4'd6, 1'b1, (k == 0) ? (S_MEM_WR | S_INC_PC) : S_MEM_WR,
                                3'd3, ALU_NOP));
    end
    // register-reference skips, priority and AC/E ops; I/O is a NOP
    add_rr(16'h7010, 4'b0000, S_INC_PC, ALU_NOP);
    add_rr(16'h7010, 4'b1000, S_NONE,   ALU_NOP);
    add_rr(16'h7008, 4'b0000, S_NONE,   ALU_NOP);
    add_rr(16'h7008, 4'b1000, S_INC_PC, ALU_NOP);
    add_rr(16'h7004, 4'b0100, S_INC_PC, ALU_NOP);
    add_rr(16'h7002, 4'b0010, S_INC_PC, ALU_NOP);
    add_rr(16'h7030, 4'b0000, S_NONE,   ALU_INC);
    add_rr(16'h7400, 4'b0000, S_NONE,   ALU_CLE);
    add_rr(16'h7200, 4'b0000, S_NONE,   ALU_CMA);
    add_rr(16'h7100, 4'b0000, S_NONE,   ALU_CME);
    add_rr(16'h7080, 4'b0000, S_NONE,   ALU_CIR);
    add_rr(16'h7040, 4'b0000, S_NONE,   ALU_CIL);
    add_rr(16'h7FFF, 4'b1111, S_NONE,   ALU_CLA);
    add_rr(16'hF800, 4'b0000, S_NONE,   ALU_NOP);
    // STA, BUN, BSA
    add_fetch(16'h3000, 4'b0000);
    add(1'b0, 16'h3000, 4'b0000, ex(4'd3, 1'b1, S_NONE, 3'd0, ALU_NOP));
    add(1'b0, 16'h3000, 4'b0000, ex(4'd4, 1'b1, S_MEM_WR, 3'd4, ALU_NOP));
    add_fetch(16'h4000, 4'b0000);
    add(1'b0, 16'h4000, 4'b0000, ex(4'd3, 1'b1, S_NONE, 3'd0, ALU_NOP));
    add(1'b0, 16'h4000, 4'b0000, ex(4'd4, 1'b1, S_LD_PC, 3'd1, ALU_NOP));
    add_fetch(16'h5040, 4'b0000);
    add(1'b0, 16'h5040, 4'b0000, ex(4'd3, 1'b1, S_NONE, 3'd0, ALU_NOP));
    add(1'b0, 16'h5040, 4'b0000, ex(4'd4, 1'b1, S_MEM_WR | S_INC_AR, 3'd2, ALU_NOP));
    add(1'b0, 16'h5040, 4'b0000, ex(4'd5, 1'b1, S_LD_PC, 3'd1, ALU_NOP));
    // HLT, idle with busy inputs, then restart
    add_rr(16'h7001, 4'b0000, S_NONE, ALU_NOP);
    for (int k = 0; k < 5; k++)
      add(1'b0, 16'h1123, 4'b1111, ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    add(1'b1, 16'h1123, 4'b0000, ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    add(1'b0, 16'h1123, 4'b0000, ex(4'd0, 1'b1, S_LD_AR, 3'd2, ALU_NOP));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk); #1;
    end

    // async reset during T1 of the restarted instruction
    start = 1'b0;
    check("pre_abort_t1", ex(4'd1, 1'b1, S_LD_IR | S_INC_PC, 3'd7, ALU_NOP));
    reset_cu = 1'b1;
    #1 check("abort_t1", ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    @(posedge clk); #1;
    reset_cu = 1'b0;
    @(posedge clk); #1;
    check("halted_after_reset", ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));

    // BSA aborted by reset in the middle of T5
    op_of_ir = 16'h5040;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("bsa_t5", ex(4'd5, 1'b1, S_LD_PC, 3'd1, ALU_NOP));
    #2 reset_cu = 1'b1;
    #1 check("bsa_abort", ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    start = 1'b1;
    @(posedge clk); #1;
    check("reset_held_edge", ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    start    = 1'b0;
    reset_cu = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", ex(4'd0, 1'b0, S_NONE, 3'd0, ALU_NOP));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("resume_t0", ex(4'd0, 1'b1, S_LD_AR, 3'd2, ALU_NOP));
    @(posedge clk); #1;
    check("resume_t1", ex(4'd1, 1'b1, S_LD_IR | S_INC_PC, 3'd7, ALU_NOP));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: WIDTH, 16, instruction/data width (operand address = op_of_ir[11:0], I = op_of_ir[WIDTH-1]).
REQ-002 Ports, one per line (name, direction, width, meaning); one clock, reset is asynchronous and active-high:
  clk  in  1  rising-edge clock
  reset_cu  in  1  async active-high reset
  start  in  1  leave halt, begin fetch at T0
  op_of_ir  in  WIDTH  current IR contents
  ac_neg, ac_zero, e_zero, dr_zero  in  1 each  datapath status flags
  sc  out  4  sequence counter (T-state index)
  running  out  1  1 = executing, 0 = halted
  ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ac, ld_ir, mem_write  out  1 each  register/memory strobes
  bus_sel  out  3  common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM
  alu_op  out  4  AC/E operation: NOP, AND, ADD, LDA, CLA, CLE, CMA, CME, CIR, CIL, INC

Function
REQ-003 sc and running are registered; all strobes, bus_sel, alu_op are combinational decodes of sc, running, op_of_ir and flags.
REQ-004 running=0: all strobes 0, bus_sel=0, alu_op=NOP, sc held at 0.
REQ-005 start=1 while running=0: next edge running<=1, sc<=0; start while running=1 ignored.
REQ-006 sc increments by 1 each cycle while running, unless a step below clears it (clear wins, next state T0).
REQ-007 T0: bus_sel=2, ld_ar.
REQ-008 T1: bus_sel=7, ld_ir, inc_pc.
REQ-009 T2: bus_sel=5, ld_ar (AR<-IR[11:0]); decode D=op_of_ir[14:12].
REQ-010 T3, D=7, I=0 (register-ref): execute highest-priority set bit of op_of_ir[11:0], bit 11 first (CLA,CLE,CMA,CME,CIR,CIL,INC,SPA,SNA,SZA,SZE,HLT); sc<=0.
REQ-011 Skips: SPA inc_pc if !ac_neg; SNA if ac_neg; SZA if ac_zero; SZE if e_zero.
REQ-012 HLT (bit 0): running<=0, sc<=0.
REQ-013 T3, D=7, I=1 (I/O): NOP, sc<=0.
REQ-014 T3, D!=7, I=1: bus_sel=7, ld_ar (indirect); I=0: no strobes.
REQ-015 AND/ADD/LDA (D=0/1/2): T4 bus_sel=7, ld_dr; T5 alu_op=AND/ADD/LDA, ld_ac, sc<=0.
REQ-016 STA (D=3): T4 bus_sel=4, mem_write, sc<=0.
REQ-017 BUN (D=4): T4 bus_sel=1, ld_pc, sc<=0.
REQ-018 BSA (D=5): T4 bus_sel=2, mem_write, inc_ar; T5 bus_sel=1, ld_pc, sc<=0.
REQ-019 ISZ (D=6): T4 bus_sel=7, ld_dr; T5 inc_dr; T6 bus_sel=3, mem_write, inc_pc iff dr_zero, sc<=0.
REQ-020 Mutual exclusion: at most one ld_* driver on bus per cycle; mem_write never with bus_sel=7.
REQ-021 sc never exceeds 6; unreachable values force sc<=0 next edge.

Reset
REQ-022 reset_cu=1: sc=0, running=0 immediately (async), all outputs 0/NOP regardless of clk.
REQ-023 Reset mid-instruction aborts it; no strobe asserted while reset_cu=1; after release, halted until start.

Structure
REQ-024 Shared package: opcode constants (D0..D6, register-ref bit indices), bus_sel encodings, alu_op encodings.
REQ-025 One sub-module: seq_counter (4-bit, async clear, sync clr/inc).

Verification
REQ-026 Reset, start, op_of_ir=0x7800 -> T0 bus_sel=2 ld_ar; T1 bus_sel=7 ld_ir inc_pc; T2 ld_ar; T3 alu_op=CLA; sc=0 at cycle 4.
REQ-027 op_of_ir=0x1123 -> T4 ld_dr bus_sel=7; T5 alu_op=ADD ld_ac; 6 cycles total.
REQ-028 op_of_ir=0xA050 -> T3 bus_sel=7 ld_ar; T5 alu_op=LDA.
REQ-029 op_of_ir=0x6010, dr_zero=1 at T6 -> mem_write, bus_sel=3, inc_pc; repeat with dr_zero=0 -> no inc_pc.
REQ-030 op_of_ir=0x7001 -> running=0 after T3; 5 idle cycles all strobes 0; start -> T0 resumes.
REQ-031 BSA 0x5040, reset_cu asserted mid-T5 -> ld_pc drops same cycle, sc=0, running=0; start resumes at T0.
